// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the handshaked data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Counter must hold LATENCY-1 down to 1; LATENCY+1 keeps LATENCY==1 at one bit.
  function automatic int cnt_w_of(input int latency);
    return $clog2(latency + 1);
  endfunction

  function automatic int addr_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response handshake bundle between the memory stage and the data memory.
interface data_mem_hs_if #(
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/be_ram.sv
// DEPTH x DATA_W array: synchronous per-byte write, asynchronous read, no reset.
module be_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_hs.sv
// Word-organised data RAM behind a valid/ready handshake, one request in flight,
// fixed LATENCY from accept to response, with alignment and range error reporting.
module data_mem_hs
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_hs_if.slave  bus
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int OFF_W = off_w_of(DATA_W);
  localparam int CNT_W = cnt_w_of(LATENCY);
  localparam int AW    = addr_w_of(DEPTH);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               lat_we;
  logic [31:0]        lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [BYTES-1:0]   lat_be;

  logic               acc_we;
  logic [31:0]        acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [BYTES-1:0]   acc_be;

  logic               accept;
  logic               access;
  logic               misalign;
  logic               err;
  logic [31:0]        idx_full;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // With a single-cycle latency the access happens on the accept edge itself,
  // so the live request fields are the only ones available.
  assign acc_we    = (LATENCY == 1) ? bus.req_we    : lat_we;
  assign acc_addr  = (LATENCY == 1) ? bus.req_addr  : lat_addr;
  assign acc_wdata = (LATENCY == 1) ? bus.req_wdata : lat_wdata;
  assign acc_be    = (LATENCY == 1) ? bus.req_be    : lat_be;

  assign idx_full = acc_addr >> OFF_W;

  generate
    if (OFF_W > 0) begin : g_align
      assign misalign = |acc_addr[OFF_W-1:0];
    end else begin : g_noalign
      assign misalign = 1'b0;
    end
  endgenerate

  assign err = misalign || (idx_full >= 32'(DEPTH));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            access    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
      lat_be    <= bus.req_be;
    end
  end

  be_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk    (clk),
    .we     (access && acc_we && !err),
    .waddr  (idx_full[AW-1:0]),
    .wdata  (acc_wdata),
    .be     (acc_be),
    .raddr  (idx_full[AW-1:0]),
    .rdata  (ram_rdata)
  );

  // Response is frozen from the access edge until the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      rdata_q <= (!acc_we && !err) ? ram_rdata : '0;
      err_q   <= err;
    end else if (state == RESP && bus.resp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
